msdap_serial_rx: RTL and testbench
==================================

Name: msdap_serial_rx

Overview:
- Input-side serial frame receiver for the MSDAP datapath, in the SCLK domain.
- Deserializes the dual-channel DCLK-timed serial stream (Frame, InputL, InputR) into parallel 16-bit left/right words.
- Feeds Rj, coefficient and data loading. Flags malformed frames.
- DCLK is treated as an asynchronous data input and is never used as a clock.

Parameters:
- WORD_WIDTH, 16, bits per frame per channel.
- SYNC_STAGES, 2, synchronizer flops applied to DCLK, Frame, InputL and InputR (minimum 2).

Ports:
- SCLK  input  1  system clock, 26.88 MHz; the only clock.
- Reset  input  1  asynchronous, active-high reset.
- Enable  input  1  receive enable (driven from InReady logic); low holds the block idle.
- DCLK  input  1  serial data clock, 768 kHz; asynchronous to SCLK.
- Frame  input  1  high for the first (MSB) bit of each word.
- InputL  input  1  left-channel serial bit, MSB first.
- InputR  input  1  right-channel serial bit, MSB first.
- DataL  output  WORD_WIDTH  last completed left word.
- DataR  output  WORD_WIDTH  last completed right word.
- DataValid  output  1  one-SCLK pulse when DataL/DataR update.
- FrameErr  output  1  one-SCLK pulse when a partial word is aborted by a new Frame.
- Busy  output  1  high while a word is partially received.

Behaviour:
- Reset (async, active-high): all outputs 0, bit counter 0, shift registers 0, synchronizers 0, state IDLE. Release takes effect on the next SCLK edge.
- Synchronization: DCLK, Frame, InputL and InputR each pass through SYNC_STAGES flops, so all four are mutually aligned. One extra DCLK history flop supports edge detection.
- Sample point: the synchronized DCLK falling edge (history=1, current=0). The transmitter changes Frame and data on the DCLK rising edge, so sampling on the fall lands mid-bit. The DCLK rising edge is ignored.
- States: IDLE, RECV.
  - IDLE, sample with Frame=1: load both shift registers with their first bit, count=1, go to RECV.
  - IDLE, sample with Frame=0: ignore the bit; no outputs.
  - RECV, sample with Frame=0: shift in MSB-first ({sr[W-2:0], bit}) and increment count. When count reaches WORD_WIDTH, register the words to DataL/DataR, pulse DataValid for the next SCLK cycle, count=0, go to IDLE.
  - RECV, sample with Frame=1 before count reaches WORD_WIDTH: pulse FrameErr for one cycle, discard the partial word, and restart with this bit as the MSB (count=1, stay in RECV). DataL/DataR are unchanged.
- Back-to-back frames: Frame on the sample immediately after a completed word (state IDLE) is legal; no FrameErr.
- Latency: DataValid rises SYNC_STAGES+2 SCLK cycles after the raw DCLK falling edge of the last bit (4 cycles at the default). Each word produces exactly one DataValid pulse.
- DataL/DataR hold their value until the next completed word.
- No backpressure: the consumer must take the word within one DCLK period (about 35 SCLK). The block buffers only a single word.
- Enable low (any cycle): go to IDLE, clear count, drop any partial word without FrameErr, suppress DataValid/FrameErr. DataL/DataR hold. The synchronizers keep running, so a DCLK fall already in flight at re-enable is sampled normally.
- Busy equals (state==RECV); it is a registered output.
- Reset mid-word: the partial word is lost and outputs clear immediately; reception resumes at the next Frame.
- Sample and Enable falling in the same cycle: Enable wins and the sample is discarded.

Test Plan:
- Reset, Enable=1, one frame L=16'h8001, R=16'h7FFE at 768 kHz -> exactly one DataValid pulse, DataL=8001, DataR=7FFE, 4 SCLK after the 16th DCLK fall; Busy high from the first sample until completion.
- 528 back-to-back frames (16 Rj, 512 coefficients) with L=index, R=~index -> 528 DataValid pulses, each word matching in order, zero FrameErr.
- Frame reasserted after 9 bits of L=16'hAAAA, then a full frame L=16'h1234 -> one FrameErr pulse at the 10th sample; next DataValid carries 1234; AAAA never appears.
- 20 DCLK cycles of data with Frame never asserted, then one frame 16'h00FF -> no pulses during the 20 cycles; one DataValid with DataL=00FF.
- Reset asserted asynchronously (between SCLK edges) after 7 bits -> outputs 0 immediately, Busy=0; the following full frame 16'hC3C3 is received correctly.
- Enable dropped for 3 DCLK periods mid-word (bit 5) -> no DataValid, no FrameErr, Busy=0; after re-enable, the next Frame-led word 16'h5A5A is received correctly.

Source files
------------

// File: rtl/msdap_serial_rx.sv
// Serial frame receiver for the MSDAP input side: deserializes the DCLK-timed
// Frame/InputL/InputR stream into parallel left/right words in the SCLK domain.
module msdap_serial_rx #(
   parameter int WORD_WIDTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  SCLK,
   input  logic                  Reset,
   input  logic                  Enable,
   input  logic                  DCLK,
   input  logic                  Frame,
   input  logic                  InputL,
   input  logic                  InputR,
   output logic [WORD_WIDTH-1:0] DataL,
   output logic [WORD_WIDTH-1:0] DataR,
   output logic                  DataValid,
   output logic                  FrameErr,
   output logic                  Busy
);

   localparam int CNT_W = $clog2(WORD_WIDTH + 1);

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   // {DCLK, Frame, InputL, InputR} travel together so they stay mutually aligned
   logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
   logic                        dclk_hist_q, dclk_hist_d;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [WORD_WIDTH-1:0]   sr_l_q, sr_l_d;
   logic [WORD_WIDTH-1:0]   sr_r_q, sr_r_d;
   logic [WORD_WIDTH-1:0]   data_l_q, data_l_d;
   logic [WORD_WIDTH-1:0]   data_r_q, data_r_d;
   logic                    valid_q, valid_d;
   logic                    err_q, err_d;

   logic dclk_s, frame_s, in_l_s, in_r_s, sample;

   assign dclk_s  = sync_q[SYNC_STAGES-1][3];
   assign frame_s = sync_q[SYNC_STAGES-1][2];
   assign in_l_s  = sync_q[SYNC_STAGES-1][1];
   assign in_r_s  = sync_q[SYNC_STAGES-1][0];
   assign sample  = dclk_hist_q & ~dclk_s;

   always_comb begin
      sync_d[0] = {DCLK, Frame, InputL, InputR};
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      dclk_hist_d = dclk_s;
   end

   // Completion is taken one cycle after the last shift, so DataValid lands
   // SYNC_STAGES+2 cycles after the raw DCLK fall.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_l_d   = sr_l_q;
      sr_r_d   = sr_r_q;
      data_l_d = data_l_q;
      data_r_d = data_r_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      if (!Enable) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sample && frame_s) begin
                  sr_l_d  = {{(WORD_WIDTH-1){1'b0}}, in_l_s};
                  sr_r_d  = {{(WORD_WIDTH-1){1'b0}}, in_r_s};
                  cnt_d   = CNT_W'(1);
                  state_d = RECV;
               end
            end
            RECV: begin
               if (cnt_q == CNT_W'(WORD_WIDTH)) begin
                  data_l_d = sr_l_q;
                  data_r_d = sr_r_q;
                  valid_d  = 1'b1;
                  cnt_d    = '0;
                  state_d  = IDLE;
               end else if (sample) begin
                  if (frame_s) begin
                     err_d  = 1'b1;
                     sr_l_d = {{(WORD_WIDTH-1){1'b0}}, in_l_s};
                     sr_r_d = {{(WORD_WIDTH-1){1'b0}}, in_r_s};
                     cnt_d  = CNT_W'(1);
                  end else begin
                     sr_l_d = {sr_l_q[WORD_WIDTH-2:0], in_l_s};
                     sr_r_d = {sr_r_q[WORD_WIDTH-2:0], in_r_s};
                     cnt_d  = cnt_q + CNT_W'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge SCLK or posedge Reset) begin
      if (Reset) begin
         sync_q      <= '0;
         dclk_hist_q <= 1'b0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         sr_l_q      <= '0;
         sr_r_q      <= '0;
         data_l_q    <= '0;
         data_r_q    <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         dclk_hist_q <= dclk_hist_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sr_l_q      <= sr_l_d;
         sr_r_q      <= sr_r_d;
         data_l_q    <= data_l_d;
         data_r_q    <= data_r_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end

   assign DataL     = data_l_q;
   assign DataR     = data_r_q;
   assign DataValid = valid_q;
   assign FrameErr  = err_q;
   assign Busy      = (state_q == RECV);

endmodule

// File: tb/tb_msdap_serial_rx.sv
// Self-checking bench for msdap_serial_rx: a DCLK-timed serial transmitter
// model feeding a scoreboard of expected left/right words.
module tb_msdap_serial_rx;

   logic        SCLK, Reset, Enable, DCLK, Frame, InputL, InputR;
   logic [15:0] DataL, DataR;
   logic        DataValid, FrameErr, Busy;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int valid_cnt = 0;
   int err_cnt   = 0;
   int half_ns   = 175;
   logic [31:0] exp_q[$];

   msdap_serial_rx #(.WORD_WIDTH(16), .SYNC_STAGES(2)) dut (
      .SCLK(SCLK), .Reset(Reset), .Enable(Enable), .DCLK(DCLK),
      .Frame(Frame), .InputL(InputL), .InputR(InputR),
      .DataL(DataL), .DataR(DataR), .DataValid(DataValid),
      .FrameErr(FrameErr), .Busy(Busy)
   );

   initial SCLK = 1'b0;
   always #5 SCLK = ~SCLK;

   // Scoreboard: every DataValid pops and compares the oldest expected word
   always @(negedge SCLK) begin
      if (!Reset) begin
         if (DataValid) begin
            logic [31:0] exp_w;
            valid_cnt++;
            total_cnt++;
            if (exp_q.size() == 0) begin
               $display("FAIL sb_unexpected: got L=%h R=%h, required no DataValid", DataL, DataR);
            end else begin
               exp_w = exp_q.pop_front();
               if ({DataL, DataR} !== exp_w)
                  $display("FAIL sb_word: got L=%h R=%h, required L=%h R=%h",
                           DataL, DataR, exp_w[31:16], exp_w[15:0]);
               else
                  pass_cnt++;
            end
         end
         if (FrameErr) err_cnt++;
      end
   end

   task automatic bit_rise(input logic f, input logic l, input logic r);
      DCLK = 1'b1; Frame = f; InputL = l; InputR = r;
      #(half_ns);
   endtask

   task automatic bit_fall();
      DCLK = 1'b0;
      #(half_ns);
   endtask

   task automatic send_bits(input logic [15:0] l, input logic [15:0] r,
                            input int first, input int last);
      for (int i = first; i <= last; i++) begin
         bit_rise(i == 0, l[15-i], r[15-i]);
         bit_fall();
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1; Enable = 1'b0; DCLK = 1'b0; Frame = 1'b0; InputL = 1'b0; InputR = 1'b0;
      repeat (3) @(posedge SCLK);
      #1;
      total_cnt++;
      if (DataL !== 16'h0) $display("FAIL rst_datal: got %h, required 0000", DataL); else pass_cnt++;
      total_cnt++;
      if (DataR !== 16'h0) $display("FAIL rst_datar: got %h, required 0000", DataR); else pass_cnt++;
      total_cnt++;
      if ({DataValid, FrameErr, Busy} !== 3'b000)
         $display("FAIL rst_flags: got %b, required 000", {DataValid, FrameErr, Busy});
      else pass_cnt++;
      @(posedge SCLK); #2;
      Reset = 1'b0; Enable = 1'b1;
   endtask

   task automatic test_single();
      logic [15:0] l, r;
      int v0;
      l = 16'h8001; r = 16'h7FFE; half_ns = 175; v0 = valid_cnt;
      exp_q.push_back({l, r});
      bit_rise(1'b1, l[15], r[15]);
      DCLK = 1'b0;
      repeat (3) @(posedge SCLK);
      #1;
      total_cnt++;
      if (Busy !== 1'b1) $display("FAIL single_busy_first: got %b, required 1", Busy); else pass_cnt++;
      #(half_ns);
      send_bits(l, r, 1, 14);
      bit_rise(1'b0, l[0], r[0]);
      DCLK = 1'b0;
      repeat (3) @(posedge SCLK);
      #1;
      total_cnt++;
      if (DataValid !== 1'b0) $display("FAIL single_early: DataValid got %b at 3 cycles, required 0", DataValid); else pass_cnt++;
      @(posedge SCLK); #1;
      total_cnt++;
      if (DataValid !== 1'b1 || DataL !== l || DataR !== r)
         $display("FAIL single_latency: at 4 cycles got DV=%b L=%h R=%h, required DV=1 L=%h R=%h",
                  DataValid, DataL, DataR, l, r);
      else pass_cnt++;
      @(posedge SCLK); #1;
      total_cnt++;
      if (DataValid !== 1'b0 || Busy !== 1'b0)
         $display("FAIL single_pulse: got DV=%b Busy=%b, required DV=0 Busy=0", DataValid, Busy);
      else pass_cnt++;
      #(half_ns);
      total_cnt++;
      if (valid_cnt - v0 !== 1) $display("FAIL single_count: got %0d pulses, required 1", valid_cnt - v0); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int v0, e0;
      logic [15:0] idx;
      v0 = valid_cnt; e0 = err_cnt; half_ns = 30;
      for (int i = 0; i < 528; i++) begin
         idx = 16'(i);
         exp_q.push_back({idx, ~idx});
         send_bits(idx, ~idx, 0, 15);
      end
      repeat (10) @(posedge SCLK);
      #1;
      total_cnt++;
      if (valid_cnt - v0 !== 528) $display("FAIL b2b_count: got %0d pulses, required 528", valid_cnt - v0); else pass_cnt++;
      total_cnt++;
      if (err_cnt - e0 !== 0) $display("FAIL b2b_ferr: got %0d FrameErr, required 0", err_cnt - e0); else pass_cnt++;
      total_cnt++;
      if (exp_q.size() !== 0) $display("FAIL b2b_left: got %0d words pending, required 0", exp_q.size()); else pass_cnt++;
      half_ns = 175;
   endtask

   task automatic test_frame_err();
      logic [15:0] l, r;
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      l = 16'h1234; r = 16'hEDCB;
      exp_q.push_back({l, r});
      send_bits(16'hAAAA, 16'h5555, 0, 8);
      bit_rise(1'b1, l[15], r[15]);
      DCLK = 1'b0;
      repeat (3) @(posedge SCLK);
      #1;
      total_cnt++;
      if (FrameErr !== 1'b1) $display("FAIL ferr_pulse: got %b at 10th sample, required 1", FrameErr); else pass_cnt++;
      #(half_ns);
      send_bits(l, r, 1, 15);
      repeat (6) @(posedge SCLK);
      #1;
      total_cnt++;
      if (err_cnt - e0 !== 1) $display("FAIL ferr_count: got %0d, required 1", err_cnt - e0); else pass_cnt++;
      total_cnt++;
      if (valid_cnt - v0 !== 1) $display("FAIL ferr_valid: got %0d pulses, required 1", valid_cnt - v0); else pass_cnt++;
   endtask

   task automatic test_no_frame();
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      for (int i = 0; i < 20; i++) begin
         bit_rise(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         bit_fall();
      end
      total_cnt++;
      if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0 || Busy !== 1'b0)
         $display("FAIL noframe_quiet: got DV=%0d FE=%0d Busy=%b, required 0 0 0",
                  valid_cnt - v0, err_cnt - e0, Busy);
      else pass_cnt++;
      exp_q.push_back({16'h00FF, 16'hFF00});
      send_bits(16'h00FF, 16'hFF00, 0, 15);
      repeat (6) @(posedge SCLK);
      #1;
      total_cnt++;
      if (valid_cnt - v0 !== 1 || DataL !== 16'h00FF)
         $display("FAIL noframe_word: got %0d pulses L=%h, required 1 pulse L=00ff", valid_cnt - v0, DataL);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int v0;
      send_bits(16'hFFFF, 16'hFFFF, 0, 6);
      @(posedge SCLK); #3;
      Reset = 1'b1;
      #1;
      total_cnt++;
      if (DataL !== 16'h0 || DataR !== 16'h0 || Busy !== 1'b0)
         $display("FAIL rstmid_clear: got L=%h R=%h Busy=%b, required 0000 0000 0", DataL, DataR, Busy);
      else pass_cnt++;
      repeat (3) @(posedge SCLK);
      #2;
      Reset = 1'b0;
      v0 = valid_cnt;
      exp_q.push_back({16'hC3C3, 16'h3C3C});
      send_bits(16'hC3C3, 16'h3C3C, 0, 15);
      repeat (6) @(posedge SCLK);
      #1;
      total_cnt++;
      if (valid_cnt - v0 !== 1 || DataL !== 16'hC3C3)
         $display("FAIL rstmid_word: got %0d pulses L=%h, required 1 pulse L=c3c3", valid_cnt - v0, DataL);
      else pass_cnt++;
   endtask

   task automatic test_enable();
      logic [15:0] l;
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt; l = 16'hF0F0;
      send_bits(l, ~l, 0, 4);
      bit_rise(1'b0, l[10], l[10]);
      Enable = 1'b0;
      bit_fall();
      for (int i = 6; i <= 7; i++) begin
         bit_rise(1'b0, l[15-i], l[15-i]);
         bit_fall();
      end
      total_cnt++;
      if (Busy !== 1'b0 || DataL !== 16'hC3C3)
         $display("FAIL en_idle: got Busy=%b L=%h, required Busy=0 L=c3c3", Busy, DataL);
      else pass_cnt++;
      bit_rise(1'b0, l[7], l[7]);
      Enable = 1'b1;
      bit_fall();
      send_bits(l, ~l, 9, 15);
      total_cnt++;
      if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0 || Busy !== 1'b0)
         $display("FAIL en_quiet: got DV=%0d FE=%0d Busy=%b, required 0 0 0",
                  valid_cnt - v0, err_cnt - e0, Busy);
      else pass_cnt++;
      exp_q.push_back({16'h5A5A, 16'hA5A5});
      send_bits(16'h5A5A, 16'hA5A5, 0, 15);
      repeat (6) @(posedge SCLK);
      #1;
      total_cnt++;
      if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0 || DataL !== 16'h5A5A || DataR !== 16'hA5A5)
         $display("FAIL en_word: got %0d pulses %0d errs L=%h R=%h, required 1 0 5a5a a5a5",
                  valid_cnt - v0, err_cnt - e0, DataL, DataR);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_frame_err();
      test_no_frame();
      test_reset_mid();
      test_enable();
      total_cnt++;
      if (exp_q.size() !== 0) $display("FAIL final_pending: got %0d words, required 0", exp_q.size()); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
